// File: rtl/rtype_exec_ctrl.sv
// rtype_exec_ctrl
// Multi-cycle IF/ID/EX/WB controller for the R-type datapath. It fetches a
// MIPS R-format word, addresses the register file read ports and latches both
// operands. It computes the ALU result, then drives the register file write
// port for the single WB cycle.
//
// Ports:
//   clk         clock, all state updates on posedge
//   Reset       synchronous active-low reset
//   Run         fetch enable, only looked at in IF
//   Inst_Addr   current PC to instruction ROM
//   Inst        instruction word at Inst_Addr
//   R_Addr_A/B  rs / rt fields of IR
//   R_Data_A/B  register file read data
//   W_Addr      rd field of IR
//   W_Data      latched ALU result
//   Write_Reg   registered write enable, high for the whole WB cycle
//   ZF / OF     zero / signed-overflow flags of the last executed instruction
//   Illegal     one-cycle pulse in WB for an unsupported instruction
module rtype_exec_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Run,
  output logic [31:0] Inst_Addr,
  input  logic [31:0] Inst,
  output logic [4:0]  R_Addr_A,
  output logic [4:0]  R_Addr_B,
  input  logic [31:0] R_Data_A,
  input  logic [31:0] R_Data_B,
  output logic [4:0]  W_Addr,
  output logic [31:0] W_Data,
  output logic        Write_Reg,
  output logic        ZF,
  output logic        OF,
  output logic        Illegal
);

  typedef enum logic [1:0] {S_IF, S_ID, S_EX, S_WB} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_pc, r_ir, r_a, r_b, r_f;
  logic        r_zf, r_of, r_wr, r_ill;

  logic [5:0]  w_funct;
  logic [4:0]  w_shamt;
  logic [31:0] w_sum, w_diff, w_alu;
  logic        w_legal, w_of;

  assign Inst_Addr = r_pc;
  assign R_Addr_A  = r_ir[25:21];
  assign R_Addr_B  = r_ir[20:16];
  assign W_Addr    = r_ir[15:11];
  assign W_Data    = r_f;
  assign Write_Reg = r_wr;
  assign ZF        = r_zf;
  assign OF        = r_of;
  assign Illegal   = r_ill;

  assign w_shamt = r_ir[10:6];
  assign w_funct = r_ir[5:0];
  assign w_sum   = r_a + r_b;
  assign w_diff  = r_a - r_b;

  always_ff @(posedge clk) begin
    if (!Reset) r_state <= S_IF;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IF:    if (Run) w_next = S_ID;
      S_ID:    w_next = S_EX;
      S_EX:    w_next = S_WB;
      S_WB:    w_next = S_IF;
      default: w_next = S_IF;
    endcase
  end

  // ALU / decode. Illegal encodings force F=0 and OF=0 so the flags still
  // update in a defined way.
  always_comb begin
    w_alu   = '0;
    w_of    = 1'b0;
    w_legal = (r_ir[31:26] == 6'd0);
    case (w_funct)
      6'b100000: begin
        w_alu = w_sum;
        w_of  = (r_a[31] == r_b[31]) && (w_sum[31] != r_a[31]);
      end
      6'b100001: w_alu = w_sum;
      6'b100010: begin
        w_alu = w_diff;
        w_of  = (r_a[31] != r_b[31]) && (w_diff[31] != r_a[31]);
      end
      6'b100011: w_alu = w_diff;
      6'b100100: w_alu = r_a & r_b;
      6'b100101: w_alu = r_a | r_b;
      6'b100110: w_alu = r_a ^ r_b;
      6'b100111: w_alu = ~(r_a | r_b);
      6'b101010: w_alu = {31'd0, ($signed(r_a) < $signed(r_b))};
      6'b101011: w_alu = {31'd0, (r_a < r_b)};
      6'b000000: w_alu = r_b << w_shamt;
      6'b000010: w_alu = r_b >> w_shamt;
      6'b000011: w_alu = $signed(r_b) >>> w_shamt;
      default:   w_legal = 1'b0;
    endcase
    if (!w_legal) begin
      w_alu = '0;
      w_of  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_pc  <= PC_RESET;
      r_ir  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_f   <= '0;
      r_zf  <= 1'b0;
      r_of  <= 1'b0;
      r_wr  <= 1'b0;
      r_ill <= 1'b0;
    end else begin
      case (r_state)
        S_IF: begin
          if (Run) begin
            r_ir <= Inst;
            r_pc <= r_pc + 32'(PC_STEP);
          end
        end
        S_ID: begin
          r_a <= R_Data_A;
          r_b <= R_Data_B;
        end
        S_EX: begin
          r_f   <= w_alu;
          r_zf  <= (w_alu == 32'd0);
          r_of  <= w_of;
          r_wr  <= w_legal && (r_ir[15:11] != 5'd0);
          r_ill <= !w_legal;
        end
        S_WB: begin
          r_wr  <= 1'b0;
          r_ill <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rtype_exec_ctrl.sv
// Testbench for rtype_exec_ctrl: models the register file, predicts each
// instruction's write-back and compares it in the WB cycle.
module tb_rtype_exec_ctrl;

  logic        clk = 1'b0;
  logic        Reset, Run;
  logic [31:0] Inst_Addr, Inst, R_Data_A, R_Data_B, W_Data;
  logic [4:0]  R_Addr_A, R_Addr_B, W_Addr;
  logic        Write_Reg, ZF, OF, Illegal;

  logic [31:0] rf [32];

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] data;
    logic        wr, zf, of, ill;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  rtype_exec_ctrl #(.PC_RESET(32'h0000_0000), .PC_STEP(4)) dut (
    .clk(clk), .Reset(Reset), .Run(Run),
    .Inst_Addr(Inst_Addr), .Inst(Inst),
    .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
    .R_Data_A(R_Data_A), .R_Data_B(R_Data_B),
    .W_Addr(W_Addr), .W_Data(W_Data), .Write_Reg(Write_Reg),
    .ZF(ZF), .OF(OF), .Illegal(Illegal)
  );

  assign R_Data_A = (R_Addr_A == 5'd0) ? 32'd0 : rf[R_Addr_A];
  assign R_Data_B = (R_Addr_B == 5'd0) ? 32'd0 : rf[R_Addr_B];

  always @(posedge clk)
    if (Write_Reg && W_Addr != 5'd0) rf[W_Addr] <= W_Data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int rs, rt, rd, sh, input logic [5:0] fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic exp_t model(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] wide;
    logic        legal;
    logic [4:0]  sh;
    sh     = inst[10:6];
    legal  = (inst[31:26] == 6'd0);
    e.data = 32'd0;
    e.of   = 1'b0;
    case (inst[5:0])
      6'h20: begin
        e.data = a + b;
        wide   = {{32{a[31]}}, a} + {{32{b[31]}}, b};
        e.of   = (wide != {{32{e.data[31]}}, e.data});
      end
      6'h21: e.data = a + b;
      6'h22: begin
        e.data = a - b;
        wide   = {{32{a[31]}}, a} - {{32{b[31]}}, b};
        e.of   = (wide != {{32{e.data[31]}}, e.data});
      end
      6'h23: e.data = a - b;
      6'h24: e.data = a & b;
      6'h25: e.data = a | b;
      6'h26: e.data = a ^ b;
      6'h27: e.data = ~(a | b);
      6'h2A: e.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h2B: e.data = (a < b) ? 32'd1 : 32'd0;
      6'h00: e.data = b << sh;
      6'h02: e.data = b >> sh;
      6'h03: e.data = 32'($signed(b) >>> sh);
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e.data = 32'd0;
      e.of   = 1'b0;
    end
    e.waddr = inst[15:11];
    e.zf    = (e.data == 32'd0);
    e.wr    = legal && (inst[15:11] != 5'd0);
    e.ill   = !legal;
    return e;
  endfunction

  // Runs one instruction from IF back to IF, checking each state's outputs.
  task automatic do_inst(input logic [31:0] inst);
    exp_t e;
    Inst = inst;
    Run  = 1'b1;
    q.push_back(model(inst, (inst[25:21] == 0) ? 32'd0 : rf[inst[25:21]],
                            (inst[20:16] == 0) ? 32'd0 : rf[inst[20:16]]));
    @(posedge clk); #1;
    Run = 1'b0;
    exp_pc = exp_pc + 32'd4;
    chk("pc_fetch", Inst_Addr, exp_pc);
    chk("raddr_a", {27'd0, R_Addr_A}, {27'd0, inst[25:21]});
    chk("wr_id", {31'd0, Write_Reg}, 32'd0);
    @(posedge clk); #1;
    chk("wr_ex", {31'd0, Write_Reg}, 32'd0);
    @(posedge clk); #1;
    e = q.pop_front();
    chk("wr_wb", {31'd0, Write_Reg}, {31'd0, e.wr});
    chk("ill_wb", {31'd0, Illegal}, {31'd0, e.ill});
    chk("waddr", {27'd0, W_Addr}, {27'd0, e.waddr});
    chk("wdata", W_Data, e.data);
    chk("zf", {31'd0, ZF}, {31'd0, e.zf});
    chk("of", {31'd0, OF}, {31'd0, e.of});
    @(posedge clk); #1;
    chk("wr_if", {31'd0, Write_Reg}, 32'd0);
    chk("ill_if", {31'd0, Illegal}, 32'd0);
    chk("pc_hold", Inst_Addr, exp_pc);
    if (e.wr) chk("rf_commit", rf[e.waddr], e.data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold_pc;
    logic [4:0]  hold_wa;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    Reset = 1'b0;
    Run   = 1'b0;
    Inst  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", Inst_Addr, 32'd0);
    chk("rst_wr", {31'd0, Write_Reg}, 32'd0);
    chk("rst_flags", {29'd0, ZF, OF, Illegal}, 32'd0);
    chk("rst_wdata", W_Data, 32'd0);
    Reset  = 1'b1;
    exp_pc = 32'd0;

    do_inst(32'h0000_0000);
    rf[1] = 32'd7; rf[2] = 32'd5;
    do_inst(32'h0022_1820);
    rf[1] = 32'h7FFF_FFFF; rf[2] = 32'd1;
    do_inst(enc(1, 2, 5, 0, 6'h20));
    do_inst(enc(1, 2, 6, 0, 6'h21));
    do_inst(enc(1, 1, 4, 0, 6'h22));
    rf[1] = 32'hFFFF_FFFF; rf[2] = 32'd1;
    do_inst(enc(1, 2, 7, 0, 6'h2A));
    do_inst(enc(1, 2, 8, 0, 6'h2B));
    do_inst(enc(2, 1, 9, 0, 6'h22));
    rf[1] = 32'h8000_0000; rf[2] = 32'd1;
    do_inst(enc(1, 2, 10, 0, 6'h22));
    do_inst(enc(1, 2, 11, 0, 6'h23));
    rf[2] = 32'h8000_0000;
    do_inst(enc(0, 2, 12, 4, 6'h03));
    do_inst(enc(0, 2, 13, 4, 6'h02));
    do_inst(enc(0, 2, 14, 1, 6'h00));
    rf[1] = 32'hF0F0_1234; rf[2] = 32'h0FF0_4321;
    do_inst(enc(1, 2, 15, 0, 6'h24));
    do_inst(enc(1, 2, 16, 0, 6'h25));
    do_inst(enc(1, 2, 17, 0, 6'h26));
    do_inst(enc(1, 2, 18, 0, 6'h27));
    do_inst({6'b001000, 5'd1, 5'd2, 5'd19, 5'd0, 6'h20});
    do_inst(enc(1, 2, 20, 0, 6'h3F));
    do_inst(enc(1, 2, 0, 0, 6'h20));
    do_inst(enc(0, 0, 0, 0, 6'h00));
    do_inst(enc(1, 2, 21, 0, 6'h25));

    hold_pc = Inst_Addr;
    hold_wa = W_Addr;
    repeat (10) begin
      @(posedge clk); #1;
      chk("stall_pc", Inst_Addr, hold_pc);
      chk("stall_ir", {27'd0, W_Addr}, {27'd0, hold_wa});
      chk("stall_wr", {31'd0, Write_Reg}, 32'd0);
    end

    rf[1] = 32'd7; rf[2] = 32'd5;
    Inst = 32'h0022_1820;
    Run  = 1'b1;
    @(posedge clk); #1;
    Run = 1'b0;
    @(posedge clk); #1;
    Reset = 1'b0;
    @(posedge clk); #1;
    chk("rstex_pc", Inst_Addr, 32'd0);
    chk("rstex_waddr", {27'd0, W_Addr}, 32'd0);
    chk("rstex_wdata", W_Data, 32'd0);
    chk("rstex_flags", {28'd0, Write_Reg, ZF, OF, Illegal}, 32'd0);
    Reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rstex_nowr", {31'd0, Write_Reg}, 32'd0);
    end
    exp_pc = 32'd0;
    do_inst(32'h0022_1820);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
